axi4lite_target_ctrl_if: RTL and testbench

AXI4-Lite target that terminates the host control bus of the DMA controller. It converts each AXI4-Lite read or write into a single held-request transaction on the internal control bus (ctrlSel/ctrlWr/ctrlAddr/ctrlWrData/ctrlWrStrbs). It sits directly upstream of the control-interface mux. It consumes the mux's ctrlWrRdy, ctrlRdData and ctrlRdValid to complete the AXI response. Only one transaction is outstanding at a time.

---
 rtl/axi4lite_target_ctrl_if.sv | 209 ++++++++++++++++++++
 tb/tb_axi4lite_target_ctrl_if.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_target_ctrl_if.sv
// axi4lite_target_ctrl_if
// Terminates the host AXI4-Lite control bus and turns each read or write into
// one held request on the internal control bus feeding the control-interface
// mux. Only one transaction is outstanding at a time.
//
// Ports:
//   clock, resetn           - clock (rising edge), async active-low reset
//   AW*/W*/B*               - AXI4-Lite write address, data and response channels
//   AR*/R*                  - AXI4-Lite read address and data channels
//   ctrlSel/ctrlWr/ctrlAddr - held control request (select, direction, byte address)
//   ctrlWrData/ctrlWrStrbs  - write payload for the control request
//   ctrlWrRdy               - write accepted by the addressed target
//   ctrlRdData/ctrlRdValid  - read return from the mux
module axi4lite_target_ctrl_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [AXI_ADDR_WIDTH-1:0] AWADDR,
    input  logic                      WVALID,
    output logic                      WREADY,
    input  logic [31:0]               WDATA,
    input  logic [3:0]                WSTRB,
    output logic                      BVALID,
    input  logic                      BREADY,
    output logic [1:0]                BRESP,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    input  logic [AXI_ADDR_WIDTH-1:0] ARADDR,
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic [31:0]               RDATA,
    output logic [1:0]                RRESP,
    output logic                      ctrlSel,
    output logic                      ctrlWr,
    output logic [10:0]               ctrlAddr,
    output logic [31:0]               ctrlWrData,
    output logic [3:0]                ctrlWrStrbs,
    input  logic                      ctrlWrRdy,
    input  logic [31:0]               ctrlRdData,
    input  logic                      ctrlRdValid
);

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned STRB_W      = 4;
    localparam int unsigned CTRL_ADDR_W = 11;
    localparam int unsigned RESP_W      = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic                     aw_ready_q, aw_ready_d;
    logic                     w_ready_q, w_ready_d;
    logic                     ar_ready_q, ar_ready_d;
    logic                     b_valid_q, b_valid_d;
    logic                     r_valid_q, r_valid_d;
    logic [DATA_W-1:0]        r_data_q, r_data_d;
    logic                     ctrl_sel_q, ctrl_sel_d;
    logic                     ctrl_wr_q, ctrl_wr_d;
    logic [CTRL_ADDR_W-1:0]   ctrl_addr_q, ctrl_addr_d;
    logic [DATA_W-1:0]        ctrl_wr_data_q, ctrl_wr_data_d;
    logic [STRB_W-1:0]        ctrl_wr_strbs_q, ctrl_wr_strbs_d;
    // 1 = read was granted last, so the write wins the next contention
    logic                     last_rd_q, last_rd_d;

    logic wr_elig_c;
    logic rd_elig_c;
    logic unused_addr_c;

    assign wr_elig_c = AWVALID && WVALID;
    assign rd_elig_c = ARVALID;

    // Only bits [10:2] of the AXI addresses reach the control bus
    assign unused_addr_c = ^{AWADDR, ARADDR};

    // Next-state and registered-output logic
    always_comb begin
        state_d         = state_q;
        aw_ready_d      = 1'b0;
        w_ready_d       = 1'b0;
        ar_ready_d      = 1'b0;
        b_valid_d       = b_valid_q;
        r_valid_d       = r_valid_q;
        r_data_d        = r_data_q;
        ctrl_sel_d      = ctrl_sel_q;
        ctrl_wr_d       = ctrl_wr_q;
        ctrl_addr_d     = ctrl_addr_q;
        ctrl_wr_data_d  = ctrl_wr_data_q;
        ctrl_wr_strbs_d = ctrl_wr_strbs_q;
        last_rd_d       = last_rd_q;

        unique case (state_q)
            IDLE: begin
                if (aw_ready_q) begin
                    // Ready pulse is up: the handshake completes on this edge
                    if (wr_elig_c) begin
                        ctrl_addr_d     = CTRL_ADDR_W'({AWADDR[CTRL_ADDR_W-1:2], 2'b00});
                        ctrl_wr_data_d  = WDATA;
                        ctrl_wr_strbs_d = WSTRB;
                        ctrl_sel_d      = 1'b1;
                        ctrl_wr_d       = 1'b1;
                        state_d         = WR_REQ;
                    end
                end else if (ar_ready_q) begin
                    if (rd_elig_c) begin
                        ctrl_addr_d = CTRL_ADDR_W'({ARADDR[CTRL_ADDR_W-1:2], 2'b00});
                        ctrl_sel_d  = 1'b1;
                        ctrl_wr_d   = 1'b0;
                        state_d     = RD_REQ;
                    end
                end else if (wr_elig_c && (!rd_elig_c || last_rd_q)) begin
                    aw_ready_d = 1'b1;
                    w_ready_d  = 1'b1;
                    last_rd_d  = 1'b0;
                end else if (rd_elig_c) begin
                    ar_ready_d = 1'b1;
                    last_rd_d  = 1'b1;
                end
            end
            WR_REQ: begin
                if (ctrlWrRdy) begin
                    ctrl_sel_d = 1'b0;
                    ctrl_wr_d  = 1'b0;
                    b_valid_d  = 1'b1;
                    state_d    = WR_RESP;
                end
            end
            WR_RESP: begin
                if (BREADY) begin
                    b_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            RD_REQ: begin
                if (ctrlRdValid) begin
                    r_data_d   = ctrlRdData;
                    ctrl_sel_d = 1'b0;
                    r_valid_d  = 1'b1;
                    state_d    = RD_RESP;
                end
            end
            RD_RESP: begin
                if (RREADY) begin
                    r_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q         <= IDLE;
            aw_ready_q      <= 1'b0;
            w_ready_q       <= 1'b0;
            ar_ready_q      <= 1'b0;
            b_valid_q       <= 1'b0;
            r_valid_q       <= 1'b0;
            r_data_q        <= '0;
            ctrl_sel_q      <= 1'b0;
            ctrl_wr_q       <= 1'b0;
            ctrl_addr_q     <= '0;
            ctrl_wr_data_q  <= '0;
            ctrl_wr_strbs_q <= '0;
            last_rd_q       <= 1'b1;
        end else begin
            state_q         <= state_d;
            aw_ready_q      <= aw_ready_d;
            w_ready_q       <= w_ready_d;
            ar_ready_q      <= ar_ready_d;
            b_valid_q       <= b_valid_d;
            r_valid_q       <= r_valid_d;
            r_data_q        <= r_data_d;
            ctrl_sel_q      <= ctrl_sel_d;
            ctrl_wr_q       <= ctrl_wr_d;
            ctrl_addr_q     <= ctrl_addr_d;
            ctrl_wr_data_q  <= ctrl_wr_data_d;
            ctrl_wr_strbs_q <= ctrl_wr_strbs_d;
            last_rd_q       <= last_rd_d;
        end
    end

    assign AWREADY     = aw_ready_q;
    assign WREADY      = w_ready_q;
    assign ARREADY     = ar_ready_q;
    assign BVALID      = b_valid_q;
    assign BRESP       = RESP_W'(0);
    assign RVALID      = r_valid_q;
    assign RDATA       = r_data_q;
    assign RRESP       = RESP_W'(0);
    assign ctrlSel     = ctrl_sel_q;
    assign ctrlWr      = ctrl_wr_q;
    assign ctrlAddr    = ctrl_addr_q;
    assign ctrlWrData  = ctrl_wr_data_q;
    assign ctrlWrStrbs = ctrl_wr_strbs_q;

endmodule

// File: tb/tb_axi4lite_target_ctrl_if.sv
// Directed testbench for axi4lite_target_ctrl_if. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_axi4lite_target_ctrl_if;

    logic        clock;
    logic        resetn;
    logic        AWVALID, AWREADY;
    logic [31:0] AWADDR;
    logic        WVALID, WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID, BREADY;
    logic [1:0]  BRESP;
    logic        ARVALID, ARREADY;
    logic [31:0] ARADDR;
    logic        RVALID, RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        ctrlSel, ctrlWr;
    logic [10:0] ctrlAddr;
    logic [31:0] ctrlWrData;
    logic [3:0]  ctrlWrStrbs;
    logic        ctrlWrRdy;
    logic [31:0] ctrlRdData;
    logic        ctrlRdValid;

    int n_checks;
    int n_fail;
    int cyc_cnt;

    axi4lite_target_ctrl_if #(.AXI_ADDR_WIDTH(32)) dut (
        .clock(clock), .resetn(resetn),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .ctrlSel(ctrlSel), .ctrlWr(ctrlWr), .ctrlAddr(ctrlAddr),
        .ctrlWrData(ctrlWrData), .ctrlWrStrbs(ctrlWrStrbs),
        .ctrlWrRdy(ctrlWrRdy), .ctrlRdData(ctrlRdData), .ctrlRdValid(ctrlRdValid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic cyc();
        @(negedge clock);
        cyc_cnt++;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        AWADDR = 32'h0000_0010; WDATA = 32'hA5A5_A5A5; WSTRB = 4'h3;
        ARADDR = 32'h0000_0020;
        repeat (3) cyc();
        n_checks++;
        if ({AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP,
             ctrlSel, ctrlWr, ctrlAddr, ctrlWrData, ctrlWrStrbs} !== 90'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: some output nonzero in reset (AWREADY=%b ARREADY=%b ctrlSel=%b RDATA=%h ctrlAddr=%h) required all 0",
                     AWREADY, ARREADY, ctrlSel, RDATA, ctrlAddr);
        end
        resetn = 1'b1;
        cyc();
        n_checks++;
        if ({AWREADY, WREADY, ARREADY, ctrlSel} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_first_grant: AW/W/AR ready,sel=%b%b%b%b required 1100",
                     AWREADY, WREADY, ARREADY, ctrlSel);
        end
        cyc();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        n_checks++;
        if ({AWREADY, WREADY, ctrlSel, ctrlWr, ctrlAddr, ctrlWrData, ctrlWrStrbs} !==
            {4'b0011, 11'h010, 32'hA5A5_A5A5, 4'h3}) begin
            n_fail++;
            $display("FAIL reset_write_req: rdy=%b%b sel=%b wr=%b addr=%h data=%h strb=%h required 0 0 1 1 010 a5a5a5a5 3",
                     AWREADY, WREADY, ctrlSel, ctrlWr, ctrlAddr, ctrlWrData, ctrlWrStrbs);
        end
        ctrlWrRdy = 1'b1; BREADY = 1'b1;
        cyc();
        ctrlWrRdy = 1'b0;
        n_checks++;
        if ({BVALID, ctrlSel, ctrlWr} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_bvalid: bvalid,sel,wr=%b%b%b required 100", BVALID, ctrlSel, ctrlWr);
        end
        cyc();
        BREADY = 1'b0;
        n_checks++;
        if (BVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bclear: BVALID=%b required 0", BVALID);
        end
    endtask

    task automatic test_write();
        bit found;
        found = 1'b0;
        AWADDR = 32'h0000_0464; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        for (int t = 0; t < 10; t++) begin
            cyc();
            if (AWREADY === 1'b1) begin found = 1'b1; break; end
        end
        n_checks++;
        if (!found || WREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL write_handshake: found=%b WREADY=%b required 1 1", found, WREADY);
        end
        cyc();
        AWVALID = 1'b0; WVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({ctrlSel, ctrlWr, ctrlAddr, ctrlWrData, ctrlWrStrbs, BVALID, AWREADY} !==
                {2'b11, 11'h464, 32'hDEAD_BEEF, 4'hF, 2'b00}) begin
                n_fail++;
                $display("FAIL write_hold_%0d: sel=%b wr=%b addr=%h data=%h strb=%h bvalid=%b awready=%b required 1 1 464 deadbeef f 0 0",
                         i, ctrlSel, ctrlWr, ctrlAddr, ctrlWrData, ctrlWrStrbs, BVALID, AWREADY);
            end
            if (i < 3) cyc();
        end
        ctrlWrRdy = 1'b1;
        cyc();
        ctrlWrRdy = 1'b0;
        n_checks++;
        if ({BVALID, BRESP, ctrlSel, ctrlWr} !== 5'b10000) begin
            n_fail++;
            $display("FAIL write_bvalid: bvalid=%b bresp=%b sel=%b wr=%b required 1 00 0 0",
                     BVALID, BRESP, ctrlSel, ctrlWr);
        end
        cyc();
        n_checks++;
        if (BVALID !== 1'b1) begin
            n_fail++;
            $display("FAIL write_bhold: BVALID=%b required 1", BVALID);
        end
        BREADY = 1'b1;
        cyc();
        BREADY = 1'b0;
        n_checks++;
        if (BVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL write_bclear: BVALID=%b required 0", BVALID);
        end
    endtask

    task automatic test_aw_before_w();
        AWADDR = 32'h0000_0100; WDATA = 32'h0BAD_F00D; WSTRB = 4'h5;
        AWVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++;
            if ({AWREADY, WREADY} !== 2'b00) begin
                n_fail++;
                $display("FAIL aw_only_%0d: AWREADY=%b WREADY=%b required 0 0", i, AWREADY, WREADY);
            end
        end
        WVALID = 1'b1;
        cyc();
        n_checks++;
        if ({AWREADY, WREADY} !== 2'b11) begin
            n_fail++;
            $display("FAIL aw_w_pulse: AWREADY=%b WREADY=%b required 1 1", AWREADY, WREADY);
        end
        cyc();
        AWVALID = 1'b0; WVALID = 1'b0;
        n_checks++;
        if ({AWREADY, WREADY, ctrlSel, ctrlWr, ctrlAddr, ctrlWrData, ctrlWrStrbs} !==
            {4'b0011, 11'h100, 32'h0BAD_F00D, 4'h5}) begin
            n_fail++;
            $display("FAIL aw_w_req: rdy=%b%b sel=%b wr=%b addr=%h data=%h strb=%h required 0 0 1 1 100 0badf00d 5",
                     AWREADY, WREADY, ctrlSel, ctrlWr, ctrlAddr, ctrlWrData, ctrlWrStrbs);
        end
        ctrlWrRdy = 1'b1; BREADY = 1'b1;
        cyc();
        ctrlWrRdy = 1'b0;
        n_checks++;
        if (BVALID !== 1'b1) begin
            n_fail++;
            $display("FAIL aw_w_bvalid: BVALID=%b required 1", BVALID);
        end
        cyc();
        BREADY = 1'b0;
    endtask

    task automatic test_read();
        bit found;
        found = 1'b0;
        ARADDR = 32'hFFFF_F063; ARVALID = 1'b1;
        for (int t = 0; t < 10; t++) begin
            cyc();
            if (ARREADY === 1'b1) begin found = 1'b1; break; end
        end
        n_checks++;
        if (!found || AWREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL read_handshake: found=%b AWREADY=%b required 1 0", found, AWREADY);
        end
        cyc();
        ARVALID = 1'b0;
        n_checks++;
        if ({ARREADY, ctrlSel, ctrlWr, ctrlAddr} !== {3'b010, 11'h060}) begin
            n_fail++;
            $display("FAIL read_req: arready=%b sel=%b wr=%b addr=%h required 0 1 0 060",
                     ARREADY, ctrlSel, ctrlWr, ctrlAddr);
        end
        // Write-ready from the mux must not complete a read
        ctrlWrRdy = 1'b1;
        cyc();
        cyc();
        ctrlWrRdy = 1'b0;
        n_checks++;
        if ({ctrlSel, RVALID, BVALID} !== 3'b100) begin
            n_fail++;
            $display("FAIL read_wait: sel=%b rvalid=%b bvalid=%b required 1 0 0", ctrlSel, RVALID, BVALID);
        end
        ctrlRdData = 32'h1234_5678; ctrlRdValid = 1'b1;
        cyc();
        ctrlRdValid = 1'b0; ctrlRdData = 32'hFFFF_0000;
        n_checks++;
        if ({RVALID, RDATA, RRESP, ctrlSel} !== {1'b1, 32'h1234_5678, 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL read_rvalid: rvalid=%b rdata=%h rresp=%b sel=%b required 1 12345678 00 0",
                     RVALID, RDATA, RRESP, ctrlSel);
        end
        cyc();
        n_checks++;
        if ({RVALID, RDATA} !== {1'b1, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL read_rhold: rvalid=%b rdata=%h required 1 12345678", RVALID, RDATA);
        end
        RREADY = 1'b1;
        cyc();
        RREADY = 1'b0;
        n_checks++;
        if ({RVALID, RDATA} !== {1'b0, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL read_rclear: rvalid=%b rdata=%h required 0 12345678", RVALID, RDATA);
        end
    endtask

    task automatic test_back_to_back();
        int last_n;
        bit found;
        bit exp_wr;
        last_n = 0;
        AWADDR = 32'h0000_07FC; WDATA = 32'h1111_2222; WSTRB = 4'hC;
        ARADDR = 32'h0000_0008;
        ctrlWrRdy = 1'b1; ctrlRdValid = 1'b1; ctrlRdData = 32'hCAFE_0001;
        BREADY = 1'b1; RREADY = 1'b1;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            exp_wr = ((k % 2) == 0);
            for (int t = 0; t < 16; t++) begin
                cyc();
                if (AWREADY === 1'b1 || ARREADY === 1'b1) begin found = 1'b1; break; end
            end
            n_checks++;
            if (!found || {AWREADY, WREADY, ARREADY} !== (exp_wr ? 3'b110 : 3'b001)) begin
                n_fail++;
                $display("FAIL contention_grant_%0d: found=%b aw,w,ar ready=%b%b%b required %s",
                         k, found, AWREADY, WREADY, ARREADY, exp_wr ? "110" : "001");
            end
            if (k > 0) begin
                n_checks++;
                if (cyc_cnt - last_n !== 4) begin
                    n_fail++;
                    $display("FAIL contention_interval_%0d: %0d cycles between grants required 4",
                             k, cyc_cnt - last_n);
                end
            end
            last_n = cyc_cnt;
        end
        cyc();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        repeat (4) cyc();
        n_checks++;
        if ({AWREADY, ARREADY, BVALID, RVALID, ctrlSel, RDATA} !== {5'b00000, 32'hCAFE_0001}) begin
            n_fail++;
            $display("FAIL contention_drain: awr=%b arr=%b bv=%b rv=%b sel=%b rdata=%h required 0 0 0 0 0 cafe0001",
                     AWREADY, ARREADY, BVALID, RVALID, ctrlSel, RDATA);
        end
        ctrlWrRdy = 1'b0; ctrlRdValid = 1'b0; BREADY = 1'b0; RREADY = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit found;
        int n_ar;
        found = 1'b0;
        ARADDR = 32'h0000_0200; ARVALID = 1'b1;
        for (int t = 0; t < 10; t++) begin
            cyc();
            if (ARREADY === 1'b1) begin found = 1'b1; break; end
        end
        cyc();
        ARVALID = 1'b0;
        n_checks++;
        if (!found || {ctrlSel, ctrlAddr} !== {1'b1, 11'h200}) begin
            n_fail++;
            $display("FAIL midreset_req: found=%b sel=%b addr=%h required 1 1 200", found, ctrlSel, ctrlAddr);
        end
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({ctrlSel, RVALID, ctrlAddr} !== 13'd0) begin
            n_fail++;
            $display("FAIL midreset_async: sel=%b rvalid=%b addr=%h required 0 0 000", ctrlSel, RVALID, ctrlAddr);
        end
        cyc();
        resetn = 1'b1;
        found = 1'b0;
        ARADDR = 32'h0000_02A8; ARVALID = 1'b1;
        ctrlRdData = 32'h55AA_33CC; ctrlRdValid = 1'b1; RREADY = 1'b1;
        for (int t = 0; t < 10; t++) begin
            cyc();
            if (ARREADY === 1'b1) begin found = 1'b1; break; end
        end
        n_ar = cyc_cnt;
        cyc();
        ARVALID = 1'b0;
        n_checks++;
        if (!found || {ctrlSel, ctrlWr, ctrlAddr} !== {2'b10, 11'h2A8}) begin
            n_fail++;
            $display("FAIL midreset_newreq: found=%b sel=%b wr=%b addr=%h required 1 1 0 2a8",
                     found, ctrlSel, ctrlWr, ctrlAddr);
        end
        cyc();
        n_checks++;
        if ({RVALID, RDATA} !== {1'b1, 32'h55AA_33CC} || cyc_cnt - n_ar !== 2) begin
            n_fail++;
            $display("FAIL midreset_read: rvalid=%b rdata=%h latency=%0d required 1 55aa33cc 2",
                     RVALID, RDATA, cyc_cnt - n_ar);
        end
        ctrlRdValid = 1'b0;
        cyc();
        RREADY = 1'b0;
        n_checks++;
        if ({RVALID, ctrlSel} !== 2'b00) begin
            n_fail++;
            $display("FAIL midreset_done: rvalid=%b sel=%b required 0 0", RVALID, ctrlSel);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc_cnt = 0;
        resetn = 1'b0;
        AWVALID = 1'b0; AWADDR = '0; WVALID = 1'b0; WDATA = '0; WSTRB = '0;
        BREADY = 1'b0; ARVALID = 1'b0; ARADDR = '0; RREADY = 1'b0;
        ctrlWrRdy = 1'b0; ctrlRdData = '0; ctrlRdValid = 1'b0;
        test_reset();
        test_write();
        test_aw_before_w();
        test_read();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
